// File: rtl/dino_motion_ctrl.sv
// Dino sprite motion: turns jump/duck buttons into sprite y position and
// animation frame, advancing once per video frame on the end-of-screen pulse.
module dino_motion_ctrl #(
   parameter int GROUND_Y = 275,
   parameter int JUMP_V   = 15,
   parameter int GRAVITY  = 1,
   parameter int ANIM_DIV = 6,
   parameter int Y_WIDTH  = 10,
   parameter int V_WIDTH  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_end,
   input  logic               up,
   input  logic               down,
   input  logic               freeze,
   output logic [Y_WIDTH-1:0] dino_y,
   output logic [1:0]         sprite_frame,
   output logic               airborne,
   output logic               ducking,
   output logic [1:0]         dbg_state
);

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_JUMP = 2'd1;
   localparam logic [1:0] S_DUCK = 2'd2;

   localparam int S_W = V_WIDTH + Y_WIDTH + 1;
   localparam int A_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   localparam logic signed [S_W-1:0]     GROUND_S  = S_W'(GROUND_Y);
   localparam logic [Y_WIDTH-1:0]        GROUND_YV = Y_WIDTH'(GROUND_Y);
   localparam logic signed [V_WIDTH-1:0] JUMP_VV   = V_WIDTH'(JUMP_V);
   localparam logic signed [V_WIDTH-1:0] G_NORM    = V_WIDTH'(GRAVITY);
   localparam logic signed [V_WIDTH-1:0] G_FAST    = V_WIDTH'(2 * GRAVITY);
   localparam logic [A_W-1:0]            ANIM_LAST = A_W'(ANIM_DIV - 1);

   logic [1:0]                state, state_n;
   logic signed [V_WIDTH-1:0] vel, vel_n;
   logic [Y_WIDTH-1:0]        dino_y_n;
   logic [A_W-1:0]            anim_cnt, anim_cnt_n;
   logic [1:0]                sprite_frame_n;
   logic                      airborne_n, ducking_n;
   logic                      jump_armed, jump_armed_n;
   logic                      frame_end_d;
   logic                      tick, step;

   logic signed [S_W-1:0]     y_ext, v_ext, ny;
   logic signed [V_WIDTH-1:0] g;
   logic                      landing;

   // One step per rising edge of frame_end, however long the pulse lasts.
   assign tick = frame_end & ~frame_end_d;
   assign step = tick & ~freeze;

   assign y_ext   = $signed({{(V_WIDTH + 1){1'b0}}, dino_y});
   assign v_ext   = $signed({{(Y_WIDTH + 1){vel[V_WIDTH-1]}}, vel});
   assign ny      = y_ext - v_ext;
   assign g       = down ? G_FAST : G_NORM;
   assign landing = vel[V_WIDTH-1] && (ny >= GROUND_S);

   assign dbg_state = state;

   always_comb begin
      state_n        = state;
      vel_n          = vel;
      dino_y_n       = dino_y;
      anim_cnt_n     = anim_cnt;
      sprite_frame_n = sprite_frame;
      airborne_n     = airborne;
      ducking_n      = ducking;
      jump_armed_n   = jump_armed;

      // Re-arm happens on any tick with the button up; takeoff needs up=1,
      // so the two never collide.
      if (!up) begin
         jump_armed_n = 1'b1;
      end

      case (state)
         S_RUN: begin
            if (up && jump_armed) begin
               state_n        = S_JUMP;
               vel_n          = JUMP_VV;
               airborne_n     = 1'b1;
               jump_armed_n   = 1'b0;
               anim_cnt_n     = '0;
               sprite_frame_n = 2'd0;
            end else if (down) begin
               state_n        = S_DUCK;
               ducking_n      = 1'b1;
               anim_cnt_n     = '0;
               sprite_frame_n = 2'd2;
            end else if (anim_cnt == ANIM_LAST) begin
               anim_cnt_n     = '0;
               sprite_frame_n = {1'b0, ~sprite_frame[0]};
            end else begin
               anim_cnt_n = anim_cnt + 1'b1;
            end
         end

         S_JUMP: begin
            sprite_frame_n = 2'd0;
            if (landing) begin
               dino_y_n   = GROUND_YV;
               vel_n      = '0;
               airborne_n = 1'b0;
               anim_cnt_n = '0;
               if (down) begin
                  state_n        = S_DUCK;
                  ducking_n      = 1'b1;
                  sprite_frame_n = 2'd2;
               end else begin
                  state_n = S_RUN;
               end
            end else begin
               // Clamp at the top of the screen rather than wrapping.
               dino_y_n = ny[S_W-1] ? '0 : ny[Y_WIDTH-1:0];
               vel_n    = vel - g;
            end
         end

         S_DUCK: begin
            sprite_frame_n = 2'd2;
            if (!down) begin
               state_n        = S_RUN;
               ducking_n      = 1'b0;
               anim_cnt_n     = '0;
               sprite_frame_n = 2'd0;
            end
         end

         default: begin
            state_n        = S_RUN;
            vel_n          = '0;
            dino_y_n       = GROUND_YV;
            anim_cnt_n     = '0;
            sprite_frame_n = 2'd0;
            airborne_n     = 1'b0;
            ducking_n      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_end_d <= 1'b0;
      end else begin
         frame_end_d <= frame_end;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_RUN;
         vel          <= '0;
         dino_y       <= GROUND_YV;
         anim_cnt     <= '0;
         sprite_frame <= 2'd0;
         airborne     <= 1'b0;
         ducking      <= 1'b0;
         jump_armed   <= 1'b1;
      end else if (step) begin
         state        <= state_n;
         vel          <= vel_n;
         dino_y       <= dino_y_n;
         anim_cnt     <= anim_cnt_n;
         sprite_frame <= sprite_frame_n;
         airborne     <= airborne_n;
         ducking      <= ducking_n;
         jump_armed   <= jump_armed_n;
      end
   end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Bench for dino_motion_ctrl: directed scenarios plus randomized button/pulse
// traffic, all checked against a frame-level physics model of the dino.
module tb_dino_motion_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_end = 1'b0;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic       freeze = 1'b0;
   logic [9:0] dino_y;
   logic [1:0] sprite_frame;
   logic       airborne;
   logic       ducking;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   dino_motion_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .frame_end    (frame_end),
      .up           (up),
      .down         (down),
      .freeze       (freeze),
      .dino_y       (dino_y),
      .sprite_frame (sprite_frame),
      .airborne     (airborne),
      .ducking      (ducking),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   // Model: mode 0 = running, 1 = in the air, 2 = ducking.
   int m_mode;
   int m_y;
   int m_v;
   int m_run_ticks;
   bit m_armed;

   task automatic model_reset();
      m_mode      = 0;
      m_y         = 275;
      m_v         = 0;
      m_run_ticks = 0;
      m_armed     = 1'b1;
   endtask

   task automatic model_tick();
      int ny;
      if (freeze) return;
      case (m_mode)
         0: begin
            if (up && m_armed) begin
               m_mode  = 1;
               m_v     = 15;
               m_armed = 1'b0;
            end else if (down) begin
               m_mode = 2;
            end else begin
               m_run_ticks++;
            end
         end
         1: begin
            ny = m_y - m_v;
            if (m_v < 0 && ny >= 275) begin
               m_y         = 275;
               m_v         = 0;
               m_mode      = down ? 2 : 0;
               m_run_ticks = 0;
            end else begin
               m_y = (ny < 0) ? 0 : ny;
               m_v = m_v - (down ? 2 : 1);
            end
         end
         default: begin
            if (!down) begin
               m_mode      = 0;
               m_run_ticks = 0;
            end
         end
      endcase
      if (!up) m_armed = 1'b1;
   endtask

   function automatic logic [13:0] model_out();
      logic [1:0] f;
      if (m_mode == 1)      f = 2'd0;
      else if (m_mode == 2) f = 2'd2;
      else                  f = 2'((m_run_ticks / 6) % 2);
      return {10'(m_y), f, (m_mode == 1), (m_mode == 2)};
   endfunction

   // Drive one frame_end pulse of len clk cycles; the model steps alongside.
   task automatic pulse(input int len);
      @(negedge clk);
      frame_end = 1'b1;
      model_tick();
      repeat (len) @(negedge clk);
      frame_end = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({dino_y, sprite_frame, airborne, ducking} !== {10'd275, 2'd0, 1'b0, 1'b0})
         $display("FAIL async_reset got y=%0d f=%0d a=%0b d=%0b want y=275 f=0 a=0 d=0",
                  dino_y, sprite_frame, airborne, ducking);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [13:0] got;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      got = {dino_y, sprite_frame, airborne, ducking};
      n_checks++;
      if (got !== model_out())
         $display("FAIL reset_state got %h want %h", got, model_out());
      else n_pass++;
      up = 1'b1;
      repeat (3) pulse(1);
      up = 1'b0;
      do_reset();
   endtask

   task automatic test_long_pulse();
      logic [13:0] got;
      up = 1'b1;
      down = 1'b0;
      pulse(4);
      n_checks++;
      if ({airborne, dino_y} !== {1'b1, 10'd275})
         $display("FAIL takeoff got a=%0b y=%0d want a=1 y=275", airborne, dino_y);
      else n_pass++;
      for (int t = 2; t <= 40; t++) begin
         pulse($urandom_range(1, 4));
         got = {dino_y, sprite_frame, airborne, ducking};
         n_checks++;
         if (got !== model_out())
            $display("FAIL jump_tick%0d got %h want %h", t, got, model_out());
         else n_pass++;
         if (t == 2 || t == 16 || t == 17 || t == 31) begin
            n_checks++;
            if (dino_y !== ((t == 2) ? 10'd260 : (t == 31) ? 10'd260 : 10'd155))
               $display("FAIL traj_tick%0d got y=%0d", t, dino_y);
            else n_pass++;
         end
         if (t == 32 || t == 40) begin
            n_checks++;
            if ({airborne, dino_y} !== {1'b0, 10'd275})
               $display("FAIL landed_tick%0d got a=%0b y=%0d want a=0 y=275", t, airborne, dino_y);
            else n_pass++;
         end
      end
      up = 1'b0;
      pulse(1);
      up = 1'b1;
      pulse(1);
      n_checks++;
      if (airborne !== 1'b1)
         $display("FAIL rearm_jump got a=%0b want a=1", airborne);
      else n_pass++;
      up = 1'b0;
      for (int t = 0; t < 40 && m_mode == 1; t++) pulse(1);
   endtask

   task automatic test_fast_fall();
      logic [13:0] got;
      int land_tick;
      up = 1'b1;
      down = 1'b0;
      land_tick = 0;
      for (int t = 1; t <= 40 && land_tick == 0; t++) begin
         if (t == 10) down = 1'b1;
         pulse(1);
         got = {dino_y, sprite_frame, airborne, ducking};
         n_checks++;
         if (got !== model_out())
            $display("FAIL fall_tick%0d got %h want %h", t, got, model_out());
         else n_pass++;
         if (t > 1 && !airborne) land_tick = t;
      end
      n_checks++;
      if (land_tick == 0 || land_tick >= 32 || sprite_frame !== 2'd2 || ducking !== 1'b1)
         $display("FAIL fast_land got tick=%0d f=%0d d=%0b want tick<32 f=2 d=1",
                  land_tick, sprite_frame, ducking);
      else n_pass++;
      up = 1'b0;
      down = 1'b0;
      pulse(1);
      n_checks++;
      if ({sprite_frame, ducking} !== {2'd0, 1'b0})
         $display("FAIL duck_release got f=%0d d=%0b want f=0 d=0", sprite_frame, ducking);
      else n_pass++;
   endtask

   task automatic test_anim();
      do_reset();
      up = 1'b0;
      down = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         pulse($urandom_range(1, 3));
         n_checks++;
         if (sprite_frame !== model_out()[3:2])
            $display("FAIL anim_tick%0d got f=%0d want f=%0d", t, sprite_frame, model_out()[3:2]);
         else n_pass++;
         if (t == 5 || t == 6 || t == 12) begin
            n_checks++;
            if (sprite_frame !== ((t == 6) ? 2'd1 : 2'd0))
               $display("FAIL anim_edge%0d got f=%0d", t, sprite_frame);
            else n_pass++;
         end
      end
      up = 1'b1;
      down = 1'b1;
      pulse(1);
      n_checks++;
      if ({airborne, ducking} !== {1'b1, 1'b0})
         $display("FAIL up_beats_down got a=%0b d=%0b want a=1 d=0", airborne, ducking);
      else n_pass++;
      up = 1'b0;
      down = 1'b0;
      for (int t = 0; t < 40 && m_mode == 1; t++) pulse(1);
   endtask

   task automatic test_freeze();
      logic [13:0] got;
      logic [9:0]  held_y;
      up = 1'b1;
      down = 1'b0;
      repeat (6) pulse(1);
      held_y = 10'(m_y);
      freeze = 1'b1;
      for (int t = 0; t < 5; t++) begin
         up = 1'($urandom_range(0, 1));
         down = 1'($urandom_range(0, 1));
         pulse($urandom_range(1, 4));
         n_checks++;
         if ({dino_y, airborne} !== {held_y, 1'b1})
            $display("FAIL frozen%0d got y=%0d a=%0b want y=%0d a=1", t, dino_y, airborne, held_y);
         else n_pass++;
      end
      freeze = 1'b0;
      up = 1'b1;
      down = 1'b0;
      for (int t = 0; t < 40 && m_mode == 1; t++) begin
         pulse(1);
         got = {dino_y, sprite_frame, airborne, ducking};
         n_checks++;
         if (got !== model_out())
            $display("FAIL resume%0d got %h want %h", t, got, model_out());
         else n_pass++;
      end
      up = 1'b0;
   endtask

   task automatic test_random();
      logic [13:0] got;
      for (int t = 0; t < 300; t++) begin
         up = ($urandom_range(0, 3) != 0);
         down = ($urandom_range(0, 3) == 0);
         freeze = ($urandom_range(0, 7) == 0);
         pulse($urandom_range(1, 4));
         got = {dino_y, sprite_frame, airborne, ducking};
         n_checks++;
         if (got !== model_out())
            $display("FAIL random%0d got %h want %h", t, got, model_out());
         else n_pass++;
      end
      freeze = 1'b0;
      up = 1'b0;
      down = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_long_pulse();
      test_fast_fall();
      test_anim();
      test_freeze();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
